// File: rtl/avalon_st_arbiter_if.sv
// avalon_st_arbiter_if
//   Bundles the NUM_SRC Avalon-ST source streams and the single merged sink
//   stream of the packet arbiter.
//   Ports / signals:
//     in_data, in_valid, in_startofpacket, in_endofpacket, in_empty : sources -> arbiter
//     in_ready                                                       : arbiter -> sources
//     out_data, out_valid, out_startofpacket, out_endofpacket,
//     out_empty, out_channel, err_no_sop                             : arbiter -> sink
//     out_ready                                                      : sink -> arbiter
//   Modports:
//     master : the arbiter side (drives in_ready and the merged out_* stream)
//     slave  : the environment side (drives the sources and out_ready)
interface avalon_st_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 256,
    parameter int EMPTY_W = 5,
    parameter int CH_W    = $clog2(NUM_SRC)
);
    logic [NUM_SRC*DATA_W-1:0]  in_data;
    logic [NUM_SRC-1:0]         in_valid;
    logic [NUM_SRC-1:0]         in_ready;
    logic [NUM_SRC-1:0]         in_startofpacket;
    logic [NUM_SRC-1:0]         in_endofpacket;
    logic [NUM_SRC*EMPTY_W-1:0] in_empty;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_startofpacket;
    logic                       out_endofpacket;
    logic [EMPTY_W-1:0]         out_empty;
    logic [CH_W-1:0]            out_channel;
    logic                       err_no_sop;

    modport master (
        input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
               out_empty, out_channel, err_no_sop
    );

    modport slave (
        output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
               out_empty, out_channel, err_no_sop
    );
endinterface

// File: rtl/avalon_st_arbiter.sv
// avalon_st_arbiter
//   Packet-granular round-robin merge of NUM_SRC Avalon-ST sources onto one
//   sink. A winning source owns the sink until its EOP beat is accepted. The
//   merged stream leaves through a one-entry output register, tagged with the
//   owning source index on out_channel.
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : avalon_st_arbiter_if.master (source streams in, merged stream out)
module avalon_st_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 256,
    parameter int EMPTY_W = 5,
    parameter int CH_W    = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    avalon_st_arbiter_if.master  bus
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      last_grant_q, last_grant_d;
    logic [CH_W-1:0]      grant_q, grant_d;
    logic                 err_q, err_d;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic [EMPTY_W-1:0]   out_empty_q, out_empty_d;
    logic [CH_W-1:0]      out_channel_q, out_channel_d;

    logic                 load;
    logic                 win_found;
    logic [CH_W-1:0]      winner;
    logic [CH_W-1:0]      sel;
    logic [NUM_SRC-1:0]   ready;
    logic                 accept;
    logic [DATA_W-1:0]    sel_data;
    logic [EMPTY_W-1:0]   sel_empty;
    logic                 sel_sop;
    logic                 sel_eop;

    logic [DATA_W-1:0]    data_arr  [NUM_SRC];
    logic [EMPTY_W-1:0]   empty_arr [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign data_arr[g]  = bus.in_data[g*DATA_W +: DATA_W];
        assign empty_arr[g] = bus.in_empty[g*EMPTY_W +: EMPTY_W];
    end

    assign load = !out_valid_q || bus.out_ready;

    // Round-robin search: first look strictly above last_grant, then wrap to
    // the sources at or below it.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && bus.in_valid[CH_W'(i)] && (CH_W'(i) > last_grant_q)) begin
                win_found = 1'b1;
                winner    = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && bus.in_valid[CH_W'(i)] && (CH_W'(i) <= last_grant_q)) begin
                win_found = 1'b1;
                winner    = CH_W'(i);
            end
        end
    end

    // Ready depends only on state, in_valid (IDLE only) and out_ready.
    always_comb begin
        ready = '0;
        if (state_q == IDLE) begin
            if (load && win_found) begin
                ready[winner] = 1'b1;
            end
        end else begin
            ready[grant_q] = load;
        end
    end

    assign sel       = (state_q == IDLE) ? winner : grant_q;
    assign accept    = |(ready & bus.in_valid);
    assign sel_data  = data_arr[sel];
    assign sel_empty = empty_arr[sel];
    assign sel_sop   = bus.in_startofpacket[sel];
    assign sel_eop   = bus.in_endofpacket[sel];

    // Sources see no ready while reset is held, so nothing is handed off
    // into a register that is being cleared.
    assign bus.in_ready = reset_n ? ready : '0;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        err_d         = err_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_empty_d   = out_empty_q;
        out_channel_d = out_channel_q;

        if (load) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d    = sel_data;
                out_sop_d     = sel_sop;
                out_eop_d     = sel_eop;
                out_empty_d   = sel_empty;
                out_channel_d = sel;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = winner;
                    if (!sel_sop) begin
                        err_d = 1'b1;
                    end
                    if (!sel_eop) begin
                        state_d = LOCK;
                        grant_d = winner;
                    end
                end
            end
            LOCK: begin
                if (accept && sel_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= CH_W'(NUM_SRC - 1);
            grant_q       <= '0;
            err_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_empty_q   <= '0;
            out_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            err_q         <= err_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_empty_q   <= out_empty_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.out_startofpacket = out_sop_q;
    assign bus.out_endofpacket   = out_eop_q;
    assign bus.out_empty         = out_empty_q;
    assign bus.out_channel       = out_channel_q;
    assign bus.err_no_sop        = err_q;

endmodule

// File: tb/tb_avalon_st_arbiter.sv
module tb_avalon_st_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 256;
    localparam int EMPTY_W = 5;
    localparam int CH_W    = 2;

    logic clk;
    logic reset_n;

    avalon_st_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) bus ();

    avalon_st_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   tag;
        logic         sop;
        logic         eop;
        logic [4:0]   empty;
        logic [1:0]   ch;
    } beat_t;

    typedef struct {
        logic [3:0]   in_valid;
        logic         out_ready;
        logic [3:0]   exp_ready;
        logic         exp_ovalid;
        logic [1:0]   exp_ch;
        logic [7:0]   exp_tag;
    } vec_t;

    beat_t srcq [NUM_SRC][$];
    beat_t expq [$];

    int n_chk  = 0;
    int n_pass = 0;

    logic               prev_acc;
    logic               prev_hold;
    logic [DATA_W-1:0]  snap_data;
    logic               snap_sop, snap_eop;
    logic [4:0]         snap_empty;
    logic [1:0]         snap_ch;
    int                 run_len, max_run;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic bit_of(input logic [15:0] v, input int i);
        return v[i[3:0]];
    endfunction

    // Present the head beat of every non-empty source queue.
    task automatic drive();
        logic [NUM_SRC*DATA_W-1:0]  d;
        logic [NUM_SRC*EMPTY_W-1:0] em;
        logic [NUM_SRC-1:0]         v, s, e;
        d = '0; em = '0; v = '0; s = '0; e = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (srcq[i].size() > 0) begin
                beat_t b;
                b = srcq[i][0];
                v  = v | (NUM_SRC'(1) << i);
                if (b.sop) s = s | (NUM_SRC'(1) << i);
                if (b.eop) e = e | (NUM_SRC'(1) << i);
                d  = d | ({{((NUM_SRC-1)*DATA_W){1'b0}}, {32{b.tag}}} << (i*DATA_W));
                em = em | ({{((NUM_SRC-1)*EMPTY_W){1'b0}}, b.empty} << (i*EMPTY_W));
            end
        end
        bus.in_valid         = v;
        bus.in_startofpacket = s;
        bus.in_endofpacket   = e;
        bus.in_data          = d;
        bus.in_empty         = em;
    endtask

    task automatic add_pkt(input int src, input int n, input logic [7:0] base,
                           input logic [7:0] sop_mask, input logic [4:0] emp,
                           input bit to_src, input bit to_exp);
        for (int j = 0; j < n; j++) begin
            beat_t b;
            b.tag   = base + 8'(j);
            b.sop   = sop_mask[j[2:0]];
            b.eop   = (j == n - 1);
            b.empty = (j == n - 1) ? emp : 5'd0;
            b.ch    = 2'(src);
            if (to_src) srcq[src].push_back(b);
            if (to_exp) expq.push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
        expq.delete();
        prev_acc  = 1'b0;
        prev_hold = 1'b0;
        run_len   = 0;
        max_run   = 0;
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_all();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // One clock: monitor at the falling edge, then retire accepted beats and
    // present the next ones just after the rising edge.
    task automatic step();
        logic [NUM_SRC-1:0] acc;
        @(negedge clk);
        if (prev_acc) chk("latency_out_valid", bus.out_valid, 1'b1);
        if (prev_hold) begin
            chk("hold_data", bus.out_data, snap_data);
            chk("hold_side", {bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_channel},
                             {snap_sop, snap_eop, snap_empty, snap_ch});
        end
        if (bus.out_valid && !bus.out_ready) chk("bp_in_ready", bus.in_ready, '0);
        if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_beat: got tag %0h ch %0d expected none", bus.out_data[7:0], bus.out_channel);
            end else begin
                beat_t x;
                x = expq.pop_front();
                chk("beat_data", bus.out_data, {32{x.tag}});
                chk("beat_sop", bus.out_startofpacket, x.sop);
                chk("beat_eop", bus.out_endofpacket, x.eop);
                chk("beat_empty", bus.out_empty, x.empty);
                chk("beat_channel", bus.out_channel, x.ch);
            end
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        snap_data  = bus.out_data;
        snap_sop   = bus.out_startofpacket;
        snap_eop   = bus.out_endofpacket;
        snap_empty = bus.out_empty;
        snap_ch    = bus.out_channel;
        prev_hold  = bus.out_valid && !bus.out_ready;
        acc        = bus.in_valid & bus.in_ready;
        prev_acc   = |acc;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bit_of(16'(acc), i) && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        drive();
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && expq.size() > 0; c++) step();
        chk(name, expq.size(), 0);
    endtask

    vec_t vt [10];

    initial begin
        // IDLE arbitration with single-beat packets; round-robin pointer carries across rows.
        vt[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h00};
        vt[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vt[2] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11};
        vt[3] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        vt[4] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h40};
        vt[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        vt[6] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h62};
        vt[7] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h62};
        vt[8] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h80};
        vt[9] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h91};

        reset_n       = 1'b0;
        bus.out_ready = 1'b1;
        clear_all();
        bus.in_valid  = 4'b1111;
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_side", {bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_channel}, '0);
        chk("rst_err", bus.err_no_sop, 1'b0);
        chk("rst_in_ready", bus.in_ready, '0);
        bus.in_valid = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            logic [NUM_SRC*DATA_W-1:0]  d;
            logic [NUM_SRC*EMPTY_W-1:0] em;
            d = '0; em = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                logic [7:0] tag;
                tag = {k[3:0], i[3:0]};
                d  = d | ({{((NUM_SRC-1)*DATA_W){1'b0}}, {32{tag}}} << (i*DATA_W));
                em = em | ({{((NUM_SRC-1)*EMPTY_W){1'b0}}, 5'(i + 1)} << (i*EMPTY_W));
            end
            bus.in_data          = d;
            bus.in_empty         = em;
            bus.in_valid         = vt[k].in_valid;
            bus.in_startofpacket = 4'b1111;
            bus.in_endofpacket   = 4'b1111;
            bus.out_ready        = vt[k].out_ready;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", k), bus.in_ready, vt[k].exp_ready);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", k), bus.out_valid, vt[k].exp_ovalid);
            if (vt[k].exp_ovalid) begin
                chk($sformatf("vec%0d_out_channel", k), bus.out_channel, vt[k].exp_ch);
                chk($sformatf("vec%0d_out_data", k), bus.out_data, {32{vt[k].exp_tag}});
            end
        end
        chk("vec_err", bus.err_no_sop, 1'b0);

        // Single source, 3-beat packet.
        do_reset();
        add_pkt(1, 3, 8'hA0, 8'h01, 5'd7, 1'b1, 1'b1);
        drive();
        drain("drain_single");

        // All four sources contend from reset.
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) add_pkt(s, 2, 8'(8'hB0 + 16*s), 8'h01, 5'(s + 3), 1'b1, 1'b1);
        drive();
        drain("drain_contention");
        chk("contention_no_bubble", max_run, 8);

        // Lock: src2 must wait for src0's EOP; mid-packet SOP is not an error.
        do_reset();
        add_pkt(0, 4, 8'hC0, 8'h05, 5'd3, 1'b1, 1'b1);
        drive();
        step();
        step();
        add_pkt(2, 2, 8'hC8, 8'h01, 5'd9, 1'b1, 1'b1);
        drive();
        #1 chk("lock_src2_wait_a", bus.in_ready[2], 1'b0);
        step();
        #1 chk("lock_src2_wait_b", bus.in_ready[2], 1'b0);
        step();
        #1 chk("lock_src2_release", bus.in_ready[2], 1'b1);
        drain("drain_lock");
        chk("lock_back_to_back", max_run, 6);
        chk("lock_mid_sop_no_err", bus.err_no_sop, 1'b0);

        // Backpressure for 3 cycles mid-packet.
        do_reset();
        add_pkt(3, 4, 8'hD0, 8'h01, 5'd12, 1'b1, 1'b1);
        drive();
        step();
        step();
        bus.out_ready = 1'b0;
        step();
        step();
        step();
        bus.out_ready = 1'b1;
        drain("drain_backpressure");

        // Single-beat packets alternate between src3 and src0, then a no-SOP first beat.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            add_pkt(3, 1, 8'(8'hE0 + k), 8'h01, 5'(k), 1'b1, 1'b0);
            add_pkt(0, 1, 8'(8'hE8 + k), 8'h01, 5'(k + 4), 1'b1, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            add_pkt(0, 1, 8'(8'hE8 + k), 8'h01, 5'(k + 4), 1'b0, 1'b1);
            add_pkt(3, 1, 8'(8'hE0 + k), 8'h01, 5'(k), 1'b0, 1'b1);
        end
        drive();
        drain("drain_alternate");
        chk("alternate_no_bubble", max_run, 6);
        chk("alternate_err_clear", bus.err_no_sop, 1'b0);
        add_pkt(1, 2, 8'hF0, 8'h00, 5'd2, 1'b1, 1'b1);
        drive();
        drain("drain_no_sop");
        chk("no_sop_err_set", bus.err_no_sop, 1'b1);
        add_pkt(2, 1, 8'hF8, 8'h01, 5'd1, 1'b1, 1'b1);
        drive();
        drain("drain_after_err");
        chk("no_sop_err_sticky", bus.err_no_sop, 1'b1);

        // Reset asserted during a 5-beat packet from src2.
        add_pkt(2, 5, 8'h50, 8'h01, 5'd6, 1'b1, 1'b1);
        drive();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_err", bus.err_no_sop, 1'b0);
        chk("midrst_in_ready", bus.in_ready, '0);
        clear_all();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();
        chk("midrst_idle_after", bus.out_valid, 1'b0);
        add_pkt(3, 2, 8'h70, 8'h01, 5'd8, 1'b1, 1'b0);
        add_pkt(0, 2, 8'h60, 8'h01, 5'd5, 1'b1, 1'b1);
        add_pkt(3, 2, 8'h70, 8'h01, 5'd8, 1'b0, 1'b1);
        drive();
        drain("drain_after_reset");
        chk("after_reset_err", bus.err_no_sop, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_st_arbiter.md
# avalon_st_arbiter

Packet-granular round-robin arbiter that merges NUM_SRC Avalon-ST source streams (256-bit data, startofpacket/endofpacket/empty) onto one Avalon-ST sink. Once a source wins, it owns the sink until its endofpacket beat is accepted, so packets are never interleaved. It sits between multiple Avalon-ST masters and a single downstream consumer. It registers the merged stream through a one-entry output stage and reports which source owns each beat.

## Interface
- NUM_SRC, 4, number of input sources; legal range 2..16
- DATA_W, 256, data width per beat
- EMPTY_W, 5, empty field width (log2 of DATA_W/8)
- CH_W, $clog2(NUM_SRC), width of out_channel

- clk  in  1  rising-edge clock, the only clock domain
- reset_n  in  1  asynchronous active-low reset
- in_data  in  NUM_SRC*DATA_W  source i is bits [i*DATA_W +: DATA_W]
- in_valid  in  NUM_SRC  per-source valid
- in_ready  out  NUM_SRC  per-source ready; combinational from state, in_valid and out_ready
- in_startofpacket  in  NUM_SRC  per-source SOP
- in_endofpacket  in  NUM_SRC  per-source EOP
- in_empty  in  NUM_SRC*EMPTY_W  per-source empty; source i is bits [i*EMPTY_W +: EMPTY_W]
- out_data  out  DATA_W  registered data
- out_valid  out  1  registered valid
- out_ready  in  1  sink ready
- out_startofpacket  out  1  registered SOP
- out_endofpacket  out  1  registered EOP
- out_empty  out  EMPTY_W  registered empty
- out_channel  out  CH_W  index of the source that owns the current out beat
- err_no_sop  out  1  sticky; set when a packet is granted whose first beat lacks SOP

## Operation
- Reset values: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, out_channel=0, err_no_sop=0, in_ready=0. State is IDLE and last_grant=NUM_SRC-1, so source 0 has first priority.
- load = !out_valid || out_ready. The output register accepts a beat only when load=1.
- IDLE state:
  - winner = first source with in_valid set, searching from last_grant+1 upward and wrapping modulo NUM_SRC.
  - When load=1 and a winner exists: in_ready[winner]=1, and all other in_ready bits are 0.
  - The beat is captured, out_channel=winner, and last_grant=winner.
  - If the beat has EOP, the FSM stays in IDLE (single-beat packet). Otherwise it goes to LOCK with grant=winner.
  - If the captured beat lacks SOP, err_no_sop is set and the beat is forwarded unchanged.
- LOCK state:
  - in_ready[grant]=load, and all other in_ready bits are 0.
  - Other sources' in_valid is ignored.
  - When the EOP beat of grant is accepted, the FSM goes to IDLE.
  - A SOP beat arriving mid-packet is forwarded and does not set an error.
- Output register:
  - If load=1 and a beat is accepted, the register is written with that beat, and out_valid is 1 next cycle.
  - If load=1 and no beat is accepted, out_valid is 0 next cycle.
  - If out_valid=1 and out_ready=0, all out_* outputs hold stable.
- Masked signals: payload of unselected sources is don't-care. in_empty is forwarded unmodified on all beats.

## Timing
- Latency: an input beat accepted at edge N appears on the out_* outputs after edge N, for one cycle minimum.
- Throughput: one beat per cycle while out_ready=1, including back-to-back packets from different sources. There is no bubble at packet boundaries, because IDLE arbitration is combinational in the same cycle as the accept.
- Backpressure: out_ready=0 while out_valid=1 drives all in_ready to 0 in that cycle.
- in_ready never depends combinationally on in_data, SOP or EMPTY; it depends only on in_valid (IDLE state only), state, and out_ready.
- Simultaneous requests: exactly one grant per IDLE cycle, following round-robin order. A source that keeps requesting waits at most NUM_SRC-1 packets.
- Reset asserted mid-packet: all state clears immediately. The partial packet is dropped and nothing is emitted until a new accept.
- err_no_sop clears only on reset.

## Test plan
- Single source: src1 sends a 3-beat packet D0..D2 with out_ready=1 -> out beats D0,D1,D2 on consecutive cycles, each 1 cycle after its accept; out_channel=1; SOP only on D0; EOP and the in_empty value only on D2.
- Contention: all 4 sources request 2-beat packets simultaneously from reset -> output order is src0, src1, src2, src3 with no idle cycle between packets (8 consecutive valid beats).
- Lock: src0 is mid-packet (4 beats) when src2 raises valid -> src2's in_ready stays 0 until src0's EOP is accepted; src2's SOP appears in the cycle immediately after src0's EOP beat on out.
- Backpressure: out_ready=0 for 3 cycles during a packet -> out_* held stable; in_ready[grant]=0; no beat is lost or duplicated; the stream resumes on out_ready=1.
- Single-beat packets plus no-SOP: src3 sends SOP+EOP beats back-to-back while src0 requests -> src3 and src0 alternate. A first beat without SOP from src1 -> err_no_sop=1 and remains set.
- Reset mid-packet: reset_n pulses low during beat 2 of 5 -> out_valid=0 and err_no_sop=0 immediately. After release, the grant starts from src0 priority.
